// File: rtl/dc_cal_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dc_cal_sched_if
// Purpose  : Control/status bundle between the calibration scheduler and its
//            host / DC compensator. Names carry the scheduler's direction.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface dc_cal_sched_if #(
  parameter int WIDTH   = 14,
  parameter int DWELL_W = 16
);
  logic                 i_start;
  logic                 i_stop;
  logic                 i_freeze;
  logic [DWELL_W-1:0]   i_dwell_len;
  logic [WIDTH-1:0]     i_lock_thr;
  logic [WIDTH-1:0]     i_est_in;      // two's complement mean estimate
  logic [4:0]           o_shift;
  logic                 o_est_clear;
  logic                 o_est_hold;
  logic                 o_busy;
  logic                 o_locked;
  logic                 o_fail;
  logic [7:0]           o_relock_cnt;

  // Host / compensator side
  modport master (
    output i_start, i_stop, i_freeze, i_dwell_len, i_lock_thr, i_est_in,
    input  o_shift, o_est_clear, o_est_hold, o_busy, o_locked, o_fail,
           o_relock_cnt
  );

  // Scheduler side
  modport slave (
    input  i_start, i_stop, i_freeze, i_dwell_len, i_lock_thr, i_est_in,
    output o_shift, o_est_clear, o_est_hold, o_busy, o_locked, o_fail,
           o_relock_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dc_cal_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dc_cal_sched
// Purpose  : Gear-shift calibration scheduler for the ADC DC-removal stage.
//            Steps the compensator tau shift from SHIFT_MIN to SHIFT_MAX as
//            each dwell window settles, then tracks and detects lock loss.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module dc_cal_sched #(
  parameter int WIDTH     = 14,
  parameter int SHIFT_MIN = 4,
  parameter int SHIFT_MAX = 15,
  parameter int DWELL_W   = 16,
  parameter int RETRY_MAX = 255
) (
  input  wire logic      clk,
  input  wire logic      reset,
  dc_cal_sched_if.slave  bus
);

  localparam int         RETRY_W     = $clog2(RETRY_MAX + 1);
  localparam logic [4:0] C_SHIFT_MIN = 5'(SHIFT_MIN);
  localparam logic [4:0] C_SHIFT_MAX = 5'(SHIFT_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACQ   = 3'd2,
    S_TRACK = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t               r_state, w_state;
  state_t               r_saved, w_saved;    // state to resume after HOLD
  logic [4:0]           r_shift, w_shift;
  logic                 r_est_clear, w_est_clear;
  logic                 r_est_hold, w_est_hold;
  logic                 r_busy, w_busy;
  logic                 r_locked, w_locked;
  logic                 r_fail, w_fail;
  logic [7:0]           r_relock_cnt, w_relock_cnt;
  logic [DWELL_W-1:0]   r_win_cnt, w_win_cnt;
  logic [RETRY_W-1:0]   r_retry, w_retry;
  logic [WIDTH-1:0]     r_snap, w_snap;      // estimate at last window start

  logic [DWELL_W-1:0]   w_dwell_m1;
  logic                 w_win_end;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH:0]       w_abs;
  logic [WIDTH-1:0]     w_delta;
  logic [WIDTH+1:0]     w_thr4;
  logic                 w_settled;
  logic                 w_lost;

  // Window end detection and settle/loss comparisons on the estimate delta
  always_comb begin
    w_dwell_m1 = (bus.i_dwell_len == '0) ? '0 : bus.i_dwell_len - DWELL_W'(1);
    w_win_end  = (r_win_cnt == w_dwell_m1);
    // Sign-extend both operands so the difference cannot wrap
    w_diff     = {bus.i_est_in[WIDTH-1], bus.i_est_in} - {r_snap[WIDTH-1], r_snap};
    w_abs      = w_diff[WIDTH] ? (~w_diff + (WIDTH+1)'(1)) : w_diff;
    w_delta    = w_abs[WIDTH] ? '1 : w_abs[WIDTH-1:0];
    w_thr4     = {bus.i_lock_thr, 2'b00};
    w_settled  = (w_delta <= bus.i_lock_thr);
    w_lost     = ({2'b00, w_delta} > w_thr4);
  end

  // Next-state and next-output logic; priority stop > start > freeze > window
  always_comb begin
    w_state      = r_state;
    w_saved      = r_saved;
    w_shift      = r_shift;
    w_est_clear  = 1'b0;
    w_est_hold   = r_est_hold;
    w_busy       = r_busy;
    w_locked     = r_locked;
    w_fail       = r_fail;
    w_relock_cnt = r_relock_cnt;
    w_win_cnt    = r_win_cnt;
    w_retry      = r_retry;
    w_snap       = r_snap;

    if (bus.i_stop) begin
      w_state    = S_IDLE;
      w_shift    = C_SHIFT_MIN;
      w_est_hold = 1'b0;
      w_busy     = 1'b0;
      w_locked   = 1'b0;
    end else if (bus.i_start) begin
      w_state      = S_CLEAR;
      w_shift      = C_SHIFT_MIN;
      w_est_clear  = 1'b1;
      w_est_hold   = 1'b0;
      w_busy       = 1'b1;
      w_locked     = 1'b0;
      w_fail       = 1'b0;
      w_relock_cnt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_shift = C_SHIFT_MIN;
          w_busy  = 1'b0;
        end
        S_CLEAR: begin
          w_state   = S_ACQ;
          w_shift   = C_SHIFT_MIN;
          w_win_cnt = '0;
          w_retry   = '0;
          w_snap    = '0;
        end
        S_ACQ, S_TRACK: begin
          if (bus.i_freeze) begin
            w_saved    = r_state;
            w_state    = S_HOLD;
            w_est_hold = 1'b1;
          end else begin
            w_win_cnt = r_win_cnt + DWELL_W'(1);
            if (w_win_end) begin
              w_win_cnt = '0;
              w_snap    = bus.i_est_in;
              if (r_state == S_ACQ) begin
                if (w_settled) begin
                  w_retry = '0;
                  if (r_shift < C_SHIFT_MAX) begin
                    w_shift = r_shift + 5'd1;
                  end else begin
                    w_state  = S_TRACK;
                    w_locked = 1'b1;
                  end
                end else begin
                  w_retry = r_retry + RETRY_W'(1);
                  if (r_retry == RETRY_W'(RETRY_MAX - 1)) begin
                    w_fail  = 1'b1;
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_shift = C_SHIFT_MIN;
                  end
                end
              end else if (w_lost) begin
                // Lock lost: re-acquire from the fast constant, keep estimate
                w_state  = S_ACQ;
                w_locked = 1'b0;
                w_shift  = C_SHIFT_MIN;
                w_retry  = '0;
                if (r_relock_cnt != 8'hFF) begin
                  w_relock_cnt = r_relock_cnt + 8'd1;
                end
              end
            end
          end
        end
        S_HOLD: begin
          if (!bus.i_freeze) begin
            w_state    = r_saved;
            w_est_hold = 1'b0;
            w_win_cnt  = '0;
            w_snap     = bus.i_est_in;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_shift = C_SHIFT_MIN;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_saved      <= S_ACQ;
      r_shift      <= C_SHIFT_MIN;
      r_est_clear  <= 1'b0;
      r_est_hold   <= 1'b0;
      r_busy       <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
      r_relock_cnt <= '0;
      r_win_cnt    <= '0;
      r_retry      <= '0;
      r_snap       <= '0;
    end else begin
      r_state      <= w_state;
      r_saved      <= w_saved;
      r_shift      <= w_shift;
      r_est_clear  <= w_est_clear;
      r_est_hold   <= w_est_hold;
      r_busy       <= w_busy;
      r_locked     <= w_locked;
      r_fail       <= w_fail;
      r_relock_cnt <= w_relock_cnt;
      r_win_cnt    <= w_win_cnt;
      r_retry      <= w_retry;
      r_snap       <= w_snap;
    end
  end

  assign bus.o_shift      = r_shift;
  assign bus.o_est_clear  = r_est_clear;
  assign bus.o_est_hold   = r_est_hold;
  assign bus.o_busy       = r_busy;
  assign bus.o_locked     = r_locked;
  assign bus.o_fail       = r_fail;
  assign bus.o_relock_cnt = r_relock_cnt;

endmodule
`default_nettype wire
